// File: rtl/mux_src_ctrl.sv
// Source stage for the 4-bit display mux: prescaler, data counters, sticky carry, button select FSM.
// Optional macro SEL_AUTO_EN adds a tick-driven automatic select advance.
module mux_src_ctrl #(
  parameter int PRESCALE   = 4,
  parameter int DEB_CYCLES = 4,
  parameter int AUTO_TICKS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [2:0] i_step,
  input  logic       i_ovf_clr,
  input  logic       i_btn,
  output logic [1:0] o_sel,
  output logic [2:0] o_data1,
  output logic [2:0] o_data2,
  output logic [2:0] o_data3,
  output logic       o_ovf
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_D1  = 2'b00,
    S_OVF = 2'b01,
    S_D2  = 2'b10
  } sel_e;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          upd;
  logic [3:0]    sum;

  assign tick = (pre_cnt == PRE_MAX);
  assign upd  = tick & i_en;
  assign sum  = {1'b0, o_data3} + {1'b0, i_step};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data1 <= 3'd0;
      o_data2 <= 3'd7;
      o_data3 <= 3'd0;
    end else if (upd) begin
      o_data1 <= o_data1 + 3'd1;
      o_data2 <= o_data2 - 3'd1;
      o_data3 <= sum[2:0];
    end
  end

  // A carry on the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf <= 1'b0;
    end else if (upd && sum[3]) begin
      o_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      o_ovf <= 1'b0;
    end
  end

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] deb_cnt;
  logic          accept;
  logic          press;

  assign accept = (sync2 != stable) && (deb_cnt == DEB_MAX);
  // Press fires on the edge that flips the stable level high.
  assign press  = accept & sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      if (sync2 == stable) begin
        deb_cnt <= '0;
      end else if (accept) begin
        stable  <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  logic adv;

`ifdef SEL_AUTO_EN
  localparam int AW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_TICKS - 1);

  logic [AW-1:0] auto_cnt;
  logic          auto_adv;

  assign auto_adv = upd && (auto_cnt == AUTO_MAX);
  assign adv      = press | auto_adv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      auto_cnt <= '0;
    end else if (press) begin
      auto_cnt <= '0;
    end else if (upd) begin
      if (auto_cnt == AUTO_MAX) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + 1'b1;
      end
    end
  end
`else
  assign adv = press;
`endif

  sel_e state;

  assign o_sel = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_D1;
    end else begin
      unique case (state)
        S_D1:    if (adv) state <= S_OVF;
        S_OVF:   if (adv) state <= S_D2;
        S_D2:    if (adv) state <= S_D1;
        default: state <= S_D1;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_src_ctrl.sv
// Directed bench for mux_src_ctrl: table-driven data/overflow vectors,
// then hand sequences for debounce, select stepping and async reset.
module tb_mux_src_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] step;
  logic       ovf_clr;
  logic       btn;
  logic [1:0] sel;
  logic [2:0] data1;
  logic [2:0] data2;
  logic [2:0] data3;
  logic       ovf;

  int n_vec;
  int n_bad;
  bit sel3_seen;

  mux_src_ctrl #(
    .PRESCALE(4),
    .DEB_CYCLES(4),
    .AUTO_TICKS(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_step(step),
    .i_ovf_clr(ovf_clr),
    .i_btn(btn),
    .o_sel(sel),
    .o_data1(data1),
    .o_data2(data2),
    .o_data3(data3),
    .o_ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && sel == 2'b11) sel3_seen = 1'b1;
  end

  typedef struct {
    logic       en;
    logic [2:0] step;
    logic       clr;
    int         cyc;
    int         d1;
    int         d2;
    int         d3;
    int         ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input int hold);
    btn = 1'b1;
    cyc(hold);
    btn = 1'b0;
    cyc(10);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    sel3_seen = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    step = 3'd0;
    ovf_clr = 1'b0;
    btn = 1'b0;

    vecs[0]  = '{1, 0, 0, 4,  1, 6, 0, 0};
    vecs[1]  = '{1, 0, 0, 12, 4, 3, 0, 0};
    vecs[2]  = '{1, 0, 0, 12, 7, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 4,  0, 7, 0, 0};
    vecs[4]  = '{0, 0, 0, 8,  0, 7, 0, 0};
    vecs[5]  = '{1, 3, 0, 4,  1, 6, 3, 0};
    vecs[6]  = '{1, 3, 0, 4,  2, 5, 6, 0};
    vecs[7]  = '{1, 3, 0, 4,  3, 4, 1, 1};
    vecs[8]  = '{1, 3, 0, 4,  4, 3, 4, 1};
    vecs[9]  = '{0, 3, 1, 1,  4, 3, 4, 0};
    vecs[10] = '{0, 3, 0, 3,  4, 3, 4, 0};
    vecs[11] = '{1, 3, 0, 4,  5, 2, 7, 0};
    vecs[12] = '{1, 1, 1, 4,  6, 1, 0, 1};
    vecs[13] = '{1, 2, 0, 4,  7, 0, 2, 1};
    vecs[14] = '{1, 7, 0, 4,  0, 7, 1, 1};
    vecs[15] = '{1, 0, 0, 3,  0, 7, 1, 1};
    vecs[16] = '{1, 0, 0, 1,  1, 6, 1, 1};

    cyc(3);
    chk("rst_sel", sel, 0);
    chk("rst_d1", data1, 0);
    chk("rst_d2", data2, 7);
    chk("rst_d3", data3, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      en = vecs[i].en;
      step = vecs[i].step;
      ovf_clr = vecs[i].clr;
      cyc(vecs[i].cyc);
      chk($sformatf("v%0d_d1", i), data1, vecs[i].d1);
      chk($sformatf("v%0d_d2", i), data2, vecs[i].d2);
      chk($sformatf("v%0d_d3", i), data3, vecs[i].d3);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
    end

    en = 1'b0;
    step = 3'd0;
    ovf_clr = 1'b0;

    btn = 1'b1;
    cyc(2);
    btn = 1'b0;
    cyc(10);
    chk("glitch_sel", sel, 0);

    btn = 1'b1;
    cyc(5);
    chk("press_early", sel, 0);
    cyc(1);
    chk("press_at6", sel, 1);
    cyc(4);
    btn = 1'b0;
    cyc(10);
    chk("release_sel", sel, 1);

    press_btn(10);
    chk("press2_sel", sel, 2);
    press_btn(10);
    chk("press3_sel", sel, 0);
    press_btn(10);
    press_btn(10);
    chk("press5_sel", sel, 2);
    chk("hold_d1", data1, 1);

    en = 1'b1;
    begin
      int k;
      k = 0;
      while (data1 != 3'd5 && k < 64) begin
        cyc(1);
        k++;
      end
      if (k >= 64) begin
        n_vec++;
        n_bad++;
        $display("FAIL d1_reach5: got %0d expected 5", data1);
      end
    end
    chk("pre_rst_ovf", ovf, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_d1", data1, 0);
    chk("arst_d2", data2, 7);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_3", data1, 0);
    cyc(1);
    chk("post_rst_4", data1, 1);

    chk("sel_never_3", int'(sel3_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
